// File: rtl/softex_pkg.sv
// softex shared types and constants.
// Carries the slot protocol types: request, update and response.
// Also carries the per-slot storage record used by softex_slot_regfile.
package softex_pkg;

  localparam int SLOT_ADDR_BITS = 8;
  localparam int NUM_LANES      = 16;
  localparam int WIDTH_IN       = 16;
  localparam int WIDTH_ACC      = 32;
  localparam int N_SLOTS        = 4;

  // FP16ALT negative infinity: a fresh slot has not seen any score yet.
  localparam logic [WIDTH_IN-1:0] SLOT_MAX_INIT = 16'hFF80;

  typedef logic [NUM_LANES-1:0][WIDTH_IN-1:0]  slot_max_t;
  typedef logic [NUM_LANES-1:0][WIDTH_ACC-1:0] slot_den_t;

  typedef enum logic {
    SLOT_ALLOC = 1'b0,
    SLOT_LOAD  = 1'b1
  } slot_req_kind_t;

  typedef enum logic {
    SLOT_UPDATE = 1'b0,
    SLOT_FREE   = 1'b1
  } slot_update_kind_t;

  typedef struct packed {
    slot_max_t maximum;
    slot_den_t denominator;
    logic      valid;
  } slot_t;

  typedef struct packed {
    slot_req_kind_t            op;
    logic [SLOT_ADDR_BITS-1:0] addr;
  } slot_req_op_t;

  typedef struct packed {
    slot_update_kind_t         op;
    logic [SLOT_ADDR_BITS-1:0] addr;
    slot_max_t                 maximum;
    slot_den_t                 denominator;
  } slot_update_op_t;

  typedef struct packed {
    logic [SLOT_ADDR_BITS-1:0] tag;
    logic                      valid;
    slot_max_t                 maximum;
    slot_den_t                 denominator;
  } slot_entry_t;

  typedef enum logic {
    RESP_IDLE = 1'b0,
    RESP_BUSY = 1'b1
  } resp_state_t;

endpackage

// File: rtl/softex_slot_lookup.sv
// Combinational tag lookup over the slot array.
// Returns the lowest-index valid tag match and the lowest-index free slot.
module softex_slot_lookup #(
  parameter int N_ENTRIES = 4,
  parameter int TAG_BITS  = 8,
  localparam int IDX_W    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic [N_ENTRIES-1:0][TAG_BITS-1:0] tag_vec,
  input  logic [N_ENTRIES-1:0]               valid_vec,
  input  logic [TAG_BITS-1:0]                query_addr,
  output logic                               hit,
  output logic [IDX_W-1:0]                   hit_idx,
  output logic                               free_found,
  output logic [IDX_W-1:0]                   free_idx
);

  logic [N_ENTRIES-1:0] match;

  for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_match
    assign match[gi] = valid_vec[gi] && (tag_vec[gi] == query_addr);
  end

  // Priority encoders: scanning downwards lets the lowest index win.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_vec[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/softex_slot_regfile.sv
// Responder for the softex slot request/update protocol.
// Holds fully-associative partial softmax state (per-lane maximum and denominator).
// ALLOC/LOAD requests get a registered response.
// UPDATE/FREE operations land at the clock edge they are presented on.
// A same-cycle request to the same slot sees the post-update state.
// Optional: define SOFTEX_SLOT_STATS_EN to add saturating hit/miss/alloc-fail counters.
module softex_slot_regfile
  import softex_pkg::*;
#(
  parameter int N_SLOTS        = softex_pkg::N_SLOTS,
  parameter int SLOT_ADDR_BITS = softex_pkg::SLOT_ADDR_BITS,
  parameter int NUM_LANES      = softex_pkg::NUM_LANES,
  parameter int WIDTH_IN       = softex_pkg::WIDTH_IN,
  parameter int WIDTH_ACC      = softex_pkg::WIDTH_ACC,
  localparam int OCC_W         = $clog2(N_SLOTS + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  slot_req_op_t    req_op_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output slot_t           resp_slot_o,
  input  logic            update_valid_i,
  input  slot_update_op_t update_op_i,
  output logic [OCC_W-1:0] occupancy_o,
  output logic            full_o
`ifdef SOFTEX_SLOT_STATS_EN
  ,
  input  logic            stat_clear_i,
  output logic [31:0]     stat_hits_o,
  output logic [31:0]     stat_misses_o,
  output logic [31:0]     stat_alloc_fail_o
`endif
);

  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  slot_entry_t entry_reg  [N_SLOTS];
  slot_entry_t entry_fwd  [N_SLOTS];
  slot_entry_t entry_next [N_SLOTS];

  logic [N_SLOTS-1:0][SLOT_ADDR_BITS-1:0] tag_vec, fwd_tag_vec;
  logic [N_SLOTS-1:0]                     valid_vec, fwd_valid_vec;

  slot_max_t init_max;
  slot_den_t init_den;

  logic             upd_hit;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_unused_free_found;
  logic [IDX_W-1:0] upd_unused_free_idx;

  logic             req_hit;
  logic [IDX_W-1:0] req_hit_idx;
  logic             req_free_found;
  logic [IDX_W-1:0] req_free_idx;

  logic             req_accept;
  logic             alloc_ok;
  logic [IDX_W-1:0] alloc_idx;
  slot_t            resp_next;
  slot_t            resp_slot_reg;
  resp_state_t      state_reg, state_next;
  logic [OCC_W-1:0] occ_count;

  // Values a freshly allocated slot starts from.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_init
    assign init_max[gi] = SLOT_MAX_INIT[WIDTH_IN-1:0];
    assign init_den[gi] = {WIDTH_ACC{1'b0}};
  end

  // Flatten stored and forwarded tags/valids for the two lookups.
  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_vec
    assign tag_vec[gi]       = entry_reg[gi].tag;
    assign valid_vec[gi]     = entry_reg[gi].valid;
    assign fwd_tag_vec[gi]   = entry_fwd[gi].tag;
    assign fwd_valid_vec[gi] = entry_fwd[gi].valid;
  end

  // Update path looks at the registered state only.
  softex_slot_lookup #(
    .N_ENTRIES (N_SLOTS),
    .TAG_BITS  (SLOT_ADDR_BITS)
  ) u_upd_lookup (
    .tag_vec    (tag_vec),
    .valid_vec  (valid_vec),
    .query_addr (update_op_i.addr),
    .hit        (upd_hit),
    .hit_idx    (upd_idx),
    .free_found (upd_unused_free_found),
    .free_idx   (upd_unused_free_idx)
  );

  // Request path looks at the state with this cycle's update already applied.
  softex_slot_lookup #(
    .N_ENTRIES (N_SLOTS),
    .TAG_BITS  (SLOT_ADDR_BITS)
  ) u_req_lookup (
    .tag_vec    (fwd_tag_vec),
    .valid_vec  (fwd_valid_vec),
    .query_addr (req_op_i.addr),
    .hit        (req_hit),
    .hit_idx    (req_hit_idx),
    .free_found (req_free_found),
    .free_idx   (req_free_idx)
  );

  // Apply the incoming UPDATE/FREE to a copy of the stored state (forwarding).
  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) entry_fwd[i] = entry_reg[i];
    if (update_valid_i && upd_hit) begin
      if (update_op_i.op == SLOT_FREE) begin
        entry_fwd[upd_idx].valid = 1'b0;
      end else begin
        entry_fwd[upd_idx].maximum     = update_op_i.maximum;
        entry_fwd[upd_idx].denominator = update_op_i.denominator;
      end
    end
  end

  assign req_ready_o = !resp_valid_o || resp_ready_i;
  assign req_accept  = req_valid_i && req_ready_o;
  assign alloc_ok    = req_hit || req_free_found;
  assign alloc_idx   = req_hit ? req_hit_idx : req_free_idx;

  // Serve the accepted request against the forwarded state; ALLOC writes a fresh slot.
  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) entry_next[i] = entry_fwd[i];
    resp_next = '0;
    if (req_accept) begin
      if (req_op_i.op == SLOT_LOAD) begin
        if (req_hit) begin
          resp_next.valid       = 1'b1;
          resp_next.maximum     = entry_fwd[req_hit_idx].maximum;
          resp_next.denominator = entry_fwd[req_hit_idx].denominator;
        end
      end else if (alloc_ok) begin
        entry_next[alloc_idx].tag         = req_op_i.addr;
        entry_next[alloc_idx].valid       = 1'b1;
        entry_next[alloc_idx].maximum     = init_max;
        entry_next[alloc_idx].denominator = init_den;
        resp_next.valid                   = 1'b1;
        resp_next.maximum                 = init_max;
        resp_next.denominator             = init_den;
      end
    end
  end

  // Slot storage, one register bank per slot.
  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
    always_ff @(posedge clk_i) begin
      if (rst_i) entry_reg[gi] <= '0;
      else       entry_reg[gi] <= entry_next[gi];
    end
  end

  // Response state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= RESP_IDLE;
    else       state_reg <= state_next;
  end

  // Response FSM: stay busy while a new request replaces a consumed response.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RESP_IDLE: if (req_accept) state_next = RESP_BUSY;
      RESP_BUSY: if (resp_ready_i) state_next = req_accept ? RESP_BUSY : RESP_IDLE;
      default:   state_next = RESP_IDLE;
    endcase
  end

  // Response payload is captured only on accept, so it holds under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i)           resp_slot_reg <= '0;
    else if (req_accept) resp_slot_reg <= resp_next;
  end

  assign resp_valid_o = (state_reg == RESP_BUSY);
  assign resp_slot_o  = resp_slot_reg;

  // Occupancy is a population count of the registered valid bits.
  always_comb begin
    occ_count = '0;
    for (int i = 0; i < N_SLOTS; i++) occ_count = occ_count + OCC_W'(valid_vec[i]);
  end

  assign occupancy_o = occ_count;
  assign full_o      = (occ_count == OCC_W'(N_SLOTS));

`ifdef SOFTEX_SLOT_STATS_EN
  logic        load_acc, alloc_fail;
  logic [31:0] hits_reg, misses_reg, fail_reg;

  assign load_acc   = req_accept && (req_op_i.op == SLOT_LOAD);
  assign alloc_fail = req_accept && (req_op_i.op == SLOT_ALLOC) && !alloc_ok;

  // Saturating event counters; clear beats a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clear_i) begin
      hits_reg   <= '0;
      misses_reg <= '0;
      fail_reg   <= '0;
    end else begin
      if (load_acc && req_hit && (hits_reg != '1))    hits_reg   <= hits_reg + 32'd1;
      if (load_acc && !req_hit && (misses_reg != '1)) misses_reg <= misses_reg + 32'd1;
      if (alloc_fail && (fail_reg != '1))             fail_reg   <= fail_reg + 32'd1;
    end
  end

  assign stat_hits_o       = hits_reg;
  assign stat_misses_o     = misses_reg;
  assign stat_alloc_fail_o = fail_reg;
`endif

endmodule

// File: tb/tb_softex_slot_regfile.sv
// Self-checking bench for softex_slot_regfile: directed table, hand sequences,
// then randomized traffic against a slot-array reference model.
`timescale 1ns/1ps
module tb_softex_slot_regfile;
  import softex_pkg::*;

  localparam int NS = 4;
  localparam logic [15:0] I16 = 16'hFF80;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready;
  slot_req_op_t    req_op;
  logic            resp_valid, resp_ready;
  slot_t           resp_slot;
  logic            update_valid;
  slot_update_op_t update_op;
  logic [2:0]      occupancy;
  logic            full;
`ifdef SOFTEX_SLOT_STATS_EN
  logic            stat_clear;
  logic [31:0]     stat_hits, stat_misses, stat_alloc_fail;
`endif

  always #5 clk = ~clk;

  softex_slot_regfile dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_slot_o    (resp_slot),
    .update_valid_i (update_valid),
    .update_op_i    (update_op),
    .occupancy_o    (occupancy),
    .full_o         (full)
`ifdef SOFTEX_SLOT_STATS_EN
    ,
    .stat_clear_i      (stat_clear),
    .stat_hits_o       (stat_hits),
    .stat_misses_o     (stat_misses),
    .stat_alloc_fail_o (stat_alloc_fail)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_slot(input string name, input slot_t act, input slot_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got valid=%0b max0=%h den0=%h expected valid=%0b max0=%h den0=%h",
               name, act.valid, act.maximum[0], act.denominator[0],
               exp.valid, exp.maximum[0], exp.denominator[0]);
    end
  endtask

  function automatic slot_t mk_slot(input logic v, input logic [15:0] m0, input logic [15:0] mr,
                                    input logic [31:0] d0);
    slot_t s;
    s = '0;
    s.valid = v;
    for (int l = 0; l < NUM_LANES; l++) s.maximum[l] = (l == 0) ? m0 : mr;
    s.denominator[0] = d0;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input slot_req_kind_t op, input logic [7:0] a);
    req_valid   = v;
    req_op.op   = op;
    req_op.addr = a;
  endtask

  task automatic set_upd(input logic v, input slot_update_kind_t op, input logic [7:0] a,
                         input logic [15:0] m0, input logic [31:0] d0);
    update_valid          = v;
    update_op             = '0;
    update_op.op          = op;
    update_op.addr        = a;
    update_op.maximum[0]  = m0;
    update_op.denominator[0] = d0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(1'b0, SLOT_LOAD, 8'h00);
    set_upd(1'b0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0);
    resp_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic              rv;
    slot_req_kind_t    rop;
    logic [7:0]        raddr;
    logic              uv;
    slot_update_kind_t uop;
    logic [7:0]        uaddr;
    logic [15:0]       umax0;
    logic [31:0]       uden0;
    logic              erv;
    logic              ev;
    logic [15:0]       emax0;
    logic [15:0]       emaxr;
    logic [31:0]       eden0;
    int                eocc;
    logic              efull;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rv, input slot_req_kind_t rop, input logic [7:0] raddr,
                              input logic uv, input slot_update_kind_t uop, input logic [7:0] uaddr,
                              input logic [15:0] umax0, input logic [31:0] uden0,
                              input logic erv, input logic ev, input logic [15:0] emax0,
                              input logic [15:0] emaxr, input logic [31:0] eden0,
                              input int eocc, input logic efull);
    vec_t v;
    v.rv = rv; v.rop = rop; v.raddr = raddr;
    v.uv = uv; v.uop = uop; v.uaddr = uaddr; v.umax0 = umax0; v.uden0 = uden0;
    v.erv = erv; v.ev = ev; v.emax0 = emax0; v.emaxr = emaxr; v.eden0 = eden0;
    v.eocc = eocc; v.efull = efull;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] m_tag   [NS];
  bit         m_valid [NS];
  slot_max_t  m_max   [NS];
  slot_den_t  m_den   [NS];
  bit         m_rv;
  slot_t      m_resp;

  function automatic int m_find(input logic [7:0] a);
    for (int i = 0; i < NS; i++) if (m_valid[i] && m_tag[i] == a) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < NS; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NS; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NS; i++) begin
      m_tag[i] = '0; m_valid[i] = 0; m_max[i] = '0; m_den[i] = '0;
    end
    m_rv = 0;
    m_resp = '0;
  endtask

  // One clock edge of behaviour: update first, then the request sees the result.
  task automatic m_step();
    bit accept;
    int k;
    slot_t r;
    accept = req_valid && (!m_rv || resp_ready);
    if (update_valid) begin
      k = m_find(update_op.addr);
      if (k >= 0) begin
        if (update_op.op == SLOT_FREE) m_valid[k] = 0;
        else begin
          m_max[k] = update_op.maximum;
          m_den[k] = update_op.denominator;
        end
      end
    end
    if (accept) begin
      r = '0;
      k = m_find(req_op.addr);
      if (req_op.op == SLOT_LOAD) begin
        if (k >= 0) begin
          r.valid = 1'b1; r.maximum = m_max[k]; r.denominator = m_den[k];
        end
      end else begin
        if (k < 0) k = m_free();
        if (k >= 0) begin
          m_tag[k] = req_op.addr; m_valid[k] = 1;
          m_max[k] = {NUM_LANES{I16}}; m_den[k] = '0;
          r = mk_slot(1'b1, I16, I16, 32'h0);
        end
      end
      m_rv = 1;
      m_resp = r;
    end else if (resp_ready) begin
      m_rv = 0;
    end
  endtask

  initial begin
    slot_t held;
`ifdef SOFTEX_SLOT_STATS_EN
    stat_clear = 1'b0;
`endif
    do_reset();
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_occupancy", occupancy, 3'd0);
    chk("reset_full", full, 1'b0);
    chk_slot("reset_resp_slot", resp_slot, '0);
    chk("reset_req_ready", req_ready, 1'b1);

    vt.push_back(mk(1, SLOT_LOAD,  8'h12, 0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0, 1, 0, 16'h0, 16'h0, 32'h0, 0, 0));
    vt.push_back(mk(1, SLOT_ALLOC, 8'h12, 0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0, 1, 1, I16, I16, 32'h0, 1, 0));
    vt.push_back(mk(0, SLOT_LOAD,  8'h00, 1, SLOT_UPDATE, 8'h12, 16'h3F80, 32'h40000000, 0, 0, 16'h0, 16'h0, 32'h0, 1, 0));
    vt.push_back(mk(1, SLOT_LOAD,  8'h12, 0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0, 1, 1, 16'h3F80, 16'h0, 32'h40000000, 1, 0));
    vt.push_back(mk(0, SLOT_LOAD,  8'h00, 1, SLOT_FREE,   8'h12, 16'h0, 32'h0, 0, 0, 16'h0, 16'h0, 32'h0, 0, 0));
    vt.push_back(mk(1, SLOT_ALLOC, 8'h01, 0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0, 1, 1, I16, I16, 32'h0, 1, 0));
    vt.push_back(mk(1, SLOT_ALLOC, 8'h02, 0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0, 1, 1, I16, I16, 32'h0, 2, 0));
    vt.push_back(mk(1, SLOT_ALLOC, 8'h03, 0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0, 1, 1, I16, I16, 32'h0, 3, 0));
    vt.push_back(mk(1, SLOT_ALLOC, 8'h04, 0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0, 1, 1, I16, I16, 32'h0, 4, 1));
    vt.push_back(mk(1, SLOT_ALLOC, 8'h05, 0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0, 1, 0, 16'h0, 16'h0, 32'h0, 4, 1));
    vt.push_back(mk(1, SLOT_ALLOC, 8'h05, 1, SLOT_FREE,   8'h02, 16'h0, 32'h0, 1, 1, I16, I16, 32'h0, 4, 1));
    vt.push_back(mk(1, SLOT_LOAD,  8'h02, 0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0, 1, 0, 16'h0, 16'h0, 32'h0, 4, 1));
    vt.push_back(mk(1, SLOT_LOAD,  8'h05, 0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0, 1, 1, I16, I16, 32'h0, 4, 1));
    vt.push_back(mk(0, SLOT_LOAD,  8'h00, 1, SLOT_FREE,   8'h01, 16'h0, 32'h0, 0, 0, 16'h0, 16'h0, 32'h0, 3, 0));
    vt.push_back(mk(1, SLOT_ALLOC, 8'h07, 0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0, 1, 1, I16, I16, 32'h0, 4, 1));
    vt.push_back(mk(1, SLOT_LOAD,  8'h07, 1, SLOT_UPDATE, 8'h07, 16'h1234, 32'h00005678, 1, 1, 16'h1234, 16'h0, 32'h00005678, 4, 1));
    vt.push_back(mk(1, SLOT_LOAD,  8'h07, 1, SLOT_FREE,   8'h07, 16'h0, 32'h0, 1, 0, 16'h0, 16'h0, 32'h0, 3, 0));
    vt.push_back(mk(1, SLOT_ALLOC, 8'h05, 1, SLOT_UPDATE, 8'h05, 16'hABCD, 32'h1, 1, 1, I16, I16, 32'h0, 3, 0));
    vt.push_back(mk(1, SLOT_LOAD,  8'h05, 0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0, 1, 1, I16, I16, 32'h0, 3, 0));
    vt.push_back(mk(1, SLOT_ALLOC, 8'h03, 1, SLOT_FREE,   8'h03, 16'h0, 32'h0, 1, 1, I16, I16, 32'h0, 3, 0));

    foreach (vt[i]) begin
      set_req(vt[i].rv, vt[i].rop, vt[i].raddr);
      set_upd(vt[i].uv, vt[i].uop, vt[i].uaddr, vt[i].umax0, vt[i].uden0);
      resp_ready = 1'b1;
      tick();
      $display("vec %0d: rv=%0b op=%0d addr=%h uv=%0b uop=%0d uaddr=%h -> resp_valid=%0b valid=%0b occ=%0d",
               i, vt[i].rv, vt[i].rop, vt[i].raddr, vt[i].uv, vt[i].uop, vt[i].uaddr,
               resp_valid, resp_slot.valid, occupancy);
      chk($sformatf("vec%0d_resp_valid", i), resp_valid, vt[i].erv);
      chk($sformatf("vec%0d_occupancy", i), occupancy, vt[i].eocc);
      chk($sformatf("vec%0d_full", i), full, vt[i].efull);
      if (vt[i].erv)
        chk_slot($sformatf("vec%0d_slot", i), resp_slot,
                 mk_slot(vt[i].ev, vt[i].emax0, vt[i].emaxr, vt[i].eden0));
    end

    // Backpressure: tag slots 03/04/05 with distinct data, then stall the response.
    set_req(1'b0, SLOT_LOAD, 8'h00);
    set_upd(1'b1, SLOT_UPDATE, 8'h03, 16'h0003, 32'h3); tick();
    set_upd(1'b1, SLOT_UPDATE, 8'h04, 16'h0004, 32'h4); tick();
    set_upd(1'b1, SLOT_UPDATE, 8'h05, 16'h0005, 32'h5); tick();
    set_upd(1'b0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0);
    chk("bp_idle_resp_valid", resp_valid, 1'b0);
    set_req(1'b1, SLOT_LOAD, 8'h03);
    resp_ready = 1'b0;
    #1;
    chk("bp_first_ready", req_ready, 1'b1);
    tick();
    $display("bp first: resp_valid=%0b max0=%h", resp_valid, resp_slot.maximum[0]);
    chk("bp_first_valid", resp_valid, 1'b1);
    held = mk_slot(1'b1, 16'h0003, 16'h0, 32'h3);
    chk_slot("bp_first_slot", resp_slot, held);
    set_req(1'b1, SLOT_LOAD, 8'h04);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_stall%0d_ready", c), req_ready, 1'b0);
      tick();
      $display("bp stall %0d: resp_valid=%0b max0=%h", c, resp_valid, resp_slot.maximum[0]);
      chk($sformatf("bp_stall%0d_valid", c), resp_valid, 1'b1);
      chk_slot($sformatf("bp_stall%0d_slot", c), resp_slot, held);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 1'b1);
    tick();
    $display("bp release: resp_valid=%0b max0=%h", resp_valid, resp_slot.maximum[0]);
    chk_slot("bp_release_slot04", resp_slot, mk_slot(1'b1, 16'h0004, 16'h0, 32'h4));
    set_req(1'b1, SLOT_LOAD, 8'h05);
    tick();
    $display("bp next: resp_valid=%0b max0=%h", resp_valid, resp_slot.maximum[0]);
    chk("bp_next_valid", resp_valid, 1'b1);
    chk_slot("bp_next_slot05", resp_slot, mk_slot(1'b1, 16'h0005, 16'h0, 32'h5));
    set_req(1'b0, SLOT_LOAD, 8'h00);
    tick();
    chk("bp_drain_valid", resp_valid, 1'b0);

    // Reset while a response is pending with three slots live.
    set_req(1'b1, SLOT_LOAD, 8'h04);
    resp_ready = 1'b0;
    tick();
    chk("rstmid_pre_valid", resp_valid, 1'b1);
    chk("rstmid_pre_occ", occupancy, 3'd3);
    rst = 1'b1;
    set_upd(1'b1, SLOT_UPDATE, 8'h04, 16'h7777, 32'h7);
    tick();
    rst = 1'b0;
    set_req(1'b0, SLOT_LOAD, 8'h00);
    set_upd(1'b0, SLOT_UPDATE, 8'h00, 16'h0, 32'h0);
    $display("reset mid: resp_valid=%0b occ=%0d full=%0b", resp_valid, occupancy, full);
    chk("rstmid_resp_valid", resp_valid, 1'b0);
    chk("rstmid_occ", occupancy, 3'd0);
    chk("rstmid_full", full, 1'b0);
`ifdef SOFTEX_SLOT_STATS_EN
    chk("rstmid_stat_hits", stat_hits, 32'd0);
    chk("rstmid_stat_misses", stat_misses, 32'd0);
    chk("rstmid_stat_alloc_fail", stat_alloc_fail, 32'd0);
`endif
    resp_ready = 1'b1;
    tick();
    chk("rstmid_after_valid", resp_valid, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    m_reset();
    for (int n = 0; n < 600; n++) begin
      slot_max_t rm;
      slot_den_t rd;
      set_req($urandom_range(0, 3) != 0,
              ($urandom_range(0, 1) != 0) ? SLOT_LOAD : SLOT_ALLOC,
              8'($urandom_range(0, 5)));
      for (int l = 0; l < NUM_LANES; l++) begin
        rm[l] = 16'($urandom);
        rd[l] = $urandom;
      end
      update_valid     = ($urandom_range(0, 2) == 0);
      update_op.op     = ($urandom_range(0, 1) != 0) ? SLOT_FREE : SLOT_UPDATE;
      update_op.addr   = 8'($urandom_range(0, 5));
      update_op.maximum     = rm;
      update_op.denominator = rd;
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk($sformatf("rnd%0d_req_ready", n), req_ready, !m_rv || resp_ready);
      m_step();
      tick();
      $display("rnd %0d: rv=%0b op=%0d a=%h uv=%0b uop=%0d ua=%h rr=%0b -> resp_valid=%0b valid=%0b occ=%0d",
               n, req_valid, req_op.op, req_op.addr, update_valid, update_op.op, update_op.addr,
               resp_ready, resp_valid, resp_slot.valid, occupancy);
      chk($sformatf("rnd%0d_resp_valid", n), resp_valid, m_rv);
      if (m_rv) chk_slot($sformatf("rnd%0d_slot", n), resp_slot, m_resp);
      chk($sformatf("rnd%0d_occ", n), occupancy, m_count());
      chk($sformatf("rnd%0d_full", n), full, m_count() == NS);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/softex_slot_regfile.md
Name: softex_slot_regfile

Overview:
- Responder end of the slot request/update protocol issued by the softex controller.
- Holds N_SLOTS fully-associative softmax partial-state slots, each tagged by a SLOT_ADDR_BITS address.
- Per slot: per-lane running maximum (WIDTH_IN) and denominator (WIDTH_ACC).
- Serves ALLOC/LOAD requests with a registered slot_t response and applies UPDATE/FREE operations, so that long rows can be processed across multiple jobs.

Parameters:
N_SLOTS, 4, number of physical slots (>=1)
SLOT_ADDR_BITS, softex_pkg::SLOT_ADDR_BITS (8), tag width
NUM_LANES, softex_pkg::NUM_LANES (16), lanes per slot
WIDTH_IN, softex_pkg::WIDTH_IN (16), maximum field width
WIDTH_ACC, softex_pkg::WIDTH_ACC (32), denominator field width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_op_i  in  slot_req_op_t  op (ALLOC/LOAD) + addr
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response ready
resp_slot_o  out  slot_t  returned maximum/denominator; .valid=1 hit/alloc ok, 0 miss/full
update_valid_i  in  1  update valid (always accepted)
update_op_i  in  slot_update_op_t  op (UPDATE/FREE) + addr + data
occupancy_o  out  $clog2(N_SLOTS+1)  number of valid slots
full_o  out  1  occupancy_o == N_SLOTS

Behaviour:
- Reset (one clk_i edge with rst_i=1): all slot valid bits 0, tags/data 0; resp_valid_o=0; resp_slot_o=0; occupancy_o=0; full_o=0. Reset mid-transaction drops any pending response.
- Reset priority: rst_i overrides every other input in the same cycle.
- Request handshake: req_ready_o = !resp_valid_o || resp_ready_i. A request is accepted on req_valid_i && req_ready_o.
- Response timing: registered response with resp_valid_o=1 the cycle after acceptance. resp_slot_o is held stable until resp_ready_i. Back-to-back throughput: 1 request/cycle.
- Two-state FSM: IDLE (resp_valid_o=0), RESP (resp_valid_o=1).
  - IDLE -> RESP on accept.
  - RESP -> RESP on resp_ready_i with a new accept.
  - RESP -> IDLE on resp_ready_i without a new accept.
- Lookup: tag match over valid slots. At most one match is guaranteed by ALLOC rules; the lowest index wins defensively.
- LOAD:
  - Hit: return stored data, .valid=1.
  - Miss: data 0, .valid=0. No state change.
- ALLOC:
  - Hit: reinitialise the matching slot; no duplicate is created.
  - Else: take the lowest-index free slot.
  - Initialisation: maximum lanes = SLOT_MAX_INIT, denominator = 0, valid=1, tag=addr; the response returns the initialised values with .valid=1.
  - Full and no hit: response .valid=0, data 0, no state change.
- UPDATE:
  - Hit: overwrite maximum/denominator.
  - Miss: ignored (no allocation).
- FREE:
  - Hit: clear valid; occupancy decrements.
  - Miss: ignored.
- Update timing: updates take effect at the clock edge of update_valid_i.
- Same-cycle update and request, same addr: the update is applied first, and the request sees the post-update state (forwarding).
  - LOAD after UPDATE returns the new data.
  - LOAD after FREE misses.
  - ALLOC after FREE may reuse the freed slot.
- Same-cycle FREE and ALLOC of different addrs while full: the ALLOC succeeds into the freed slot.
- Occupancy:
  - occupancy_o updates combinationally from the registered valid bits (reflects the state after the last edge).
  - Never exceeds N_SLOTS and never underflows.

Optional Feature:
- Macro SOFTEX_SLOT_STATS_EN.
- Defined: adds outputs stat_hits_o, stat_misses_o, stat_alloc_fail_o (32-bit each), plus input stat_clear_i.
  - Counters count accepted LOAD hits, LOAD misses, and ALLOC-when-full respectively.
  - Counters saturate at 2^32-1.
  - Counters are cleared by rst_i or stat_clear_i; stat_clear_i wins over a same-cycle increment.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- softex_pkg gains:
  - N_SLOTS;
  - SLOT_MAX_INIT = FP16ALT -inf (16'hFF80);
  - typedef slot_entry_t {tag, valid, maximum, denominator}.
- Existing slot_t, slot_req_op_t and slot_update_op_t are reused unchanged.
- One sub-module: softex_slot_lookup, combinational.
  - Inputs: tag vector, valid vector, query addr.
  - Outputs: hit, hit_idx, free_found, free_idx (lowest-index priority encoders).
  - Instantiated twice: once for the request path (with forwarded state) and once for the update path.

Test Plan:
- Reset, then LOAD addr 0x12 -> resp .valid=0, data 0, occupancy_o=0.
- ALLOC 0x12 -> resp .valid=1, all maximum lanes 16'hFF80, denominator 0, occupancy_o=1. Then UPDATE 0x12 with max lane0=16'h3F80, den lane0=32'h40000000, then LOAD 0x12 -> returns exactly those values.
- ALLOC 0x01..0x04 (N_SLOTS=4) -> full_o=1. ALLOC 0x05 -> .valid=0, occupancy stays 4. FREE 0x02 together with ALLOC 0x05 in the same cycle -> .valid=1, slot 1 reused, occupancy 4.
- UPDATE 0x07 and LOAD 0x07 in the same cycle on an allocated slot -> response carries the new data. Same-cycle FREE 0x07 with LOAD 0x07 -> miss.
- Hold resp_ready_i=0 for 3 cycles with req_valid_i=1 -> req_ready_o=0, resp_slot_o stable. Then release -> one response per cycle, no loss or duplication.
- Assert rst_i while resp_valid_o=1 with 3 slots valid -> next cycle resp_valid_o=0, occupancy_o=0. With SOFTEX_SLOT_STATS_EN defined, all counters read 0.
